// File: rtl/host_bus_initiator.sv
// host_bus_initiator: queued host commands issued one at a time on AW/W/AR/R with per-phase timeout
module host_bus_initiator #(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic        rsp_error,
  output logic [31:0] rsp_rdata,
  output logic        AWVALID,
  output logic [31:0] AWADDR,
  input  logic        AWREADY,
  output logic        WDVALID,
  output logic [31:0] WDATA,
  input  logic        WDREADY,
  output logic        ARVALID,
  output logic [31:0] ARADDR,
  input  logic        ARREADY,
  output logic        RDREADY,
  input  logic        RDVALID,
  input  logic [31:0] RDATA,
  output logic        busy
);
  localparam int PW = $clog2(CMD_DEPTH) + 1;
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_AR, S_R, S_RSP} state_t;
  state_t state, nxt;
  logic [64:0] mem [CMD_DEPTH];
  logic [64:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic full, empty, push, pop, phase, tmo, hs, err_set;
  logic cur_write;
  logic [31:0] cur_addr, cur_wdata;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign push = cmd_valid && !full;
  assign pop = state == S_IDLE && !empty;
  assign head = mem[rd_ptr[PW-2:0]];
  assign phase = state == S_AW || state == S_W || state == S_AR || state == S_R;
  assign tmo = (TIMEOUT != 0) && cnt == TLIM;
  assign err_set = phase && tmo && !hs;
  // command storage; entries need no reset since the pointers gate them
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-2:0]] <= {cmd_write, cmd_addr, cmd_wdata};
  end
  // FIFO pointers, wrapping naturally with an extra MSB to tell full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= nxt;
  end
  // next state: each bus phase advances on its handshake or falls to RSP on timeout
  always_comb begin
    nxt = state;
    hs = 1'b0;
    case (state)
      S_IDLE: nxt = empty ? S_IDLE : head[64] ? S_AW : S_AR;
      S_AW: begin
        hs = AWREADY;
        nxt = AWREADY ? S_W : tmo ? S_RSP : S_AW;
      end
      S_W: begin
        hs = WDREADY;
        nxt = (WDREADY || tmo) ? S_RSP : S_W;
      end
      S_AR: begin
        hs = ARREADY;
        nxt = ARREADY ? S_R : tmo ? S_RSP : S_AR;
      end
      S_R: begin
        hs = RDVALID;
        nxt = (RDVALID || tmo) ? S_RSP : S_R;
      end
      S_RSP: nxt = rsp_ready ? S_IDLE : S_RSP;
      default: nxt = S_IDLE;
    endcase
  end
  // current command, phase counter and response fields
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      cur_write <= 1'b0;
      cur_addr <= '0;
      cur_wdata <= '0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      cnt <= (nxt != state || !phase) ? '0 : (&cnt) ? cnt : cnt + CW'(1);
      if (pop) begin
        {cur_write, cur_addr, cur_wdata} <= head;
        rsp_error <= 1'b0;
        rsp_rdata <= '0;
      end
      if (err_set) rsp_error <= 1'b1;
      if (state == S_R && RDVALID) rsp_rdata <= RDATA;
    end
  end
  assign cmd_ready = !full;
  assign AWVALID = state == S_AW;
  assign AWADDR = AWVALID ? cur_addr : '0;
  assign WDVALID = state == S_W;
  assign WDATA = WDVALID ? cur_wdata : '0;
  assign ARVALID = state == S_AR;
  assign ARADDR = ARVALID ? cur_addr : '0;
  assign RDREADY = state == S_R;
  assign rsp_valid = state == S_RSP;
  assign rsp_write = cur_write;
  assign busy = state != S_IDLE || !empty;
endmodule

// File: tb/tb_host_bus_initiator.sv
// tb_host_bus_initiator: directed checks of latency, stalls, FIFO full, timeout, reset and ordering
module tb_host_bus_initiator;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_error;
  logic [31:0] rsp_rdata;
  logic AWVALID, AWREADY = 1'b1, WDVALID, WDREADY = 1'b1, ARVALID, ARREADY = 1'b1;
  logic RDREADY, RDVALID = 1'b1, busy;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA = '0;
  int checks = 0, errors = 0;
  logic mon = 1'b0;
  int n = 0, m = 0, r = 0;
  logic [31:0] exp_a [5];
  logic [31:0] exp_d [4];
  logic exp_w [5];

  host_bus_initiator #(.CMD_DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
    .WDVALID(WDVALID), .WDATA(WDATA), .WDREADY(WDREADY),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .RDREADY(RDREADY), .RDVALID(RDVALID), .RDATA(RDATA),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic mon_step();
    if (AWVALID || ARVALID) begin
      chk1("mm_idx", n < 5, 1'b1);
      if (n < 5) begin
        chk32("mm_addr", AWVALID ? AWADDR : ARADDR, exp_a[n]);
        chk1("mm_kind", AWVALID, exp_w[n]);
      end
      n++;
    end
    if (WDVALID) begin
      chk1("mm_widx", m < 4, 1'b1);
      if (m < 4) chk32("mm_wdata", WDATA, exp_d[m]);
      m++;
    end
    if (rsp_valid && rsp_ready) begin
      chk1("mm_ridx", r < 5, 1'b1);
      if (r < 5) begin
        chk1("mm_rsp_write", rsp_write, exp_w[r]);
        chk1("mm_rsp_error", rsp_error, 1'b0);
        chk32("mm_rsp_rdata", rsp_rdata, exp_w[r] ? 32'h0 : 32'hCAFEF00D);
      end
      r++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon) mon_step();
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    exp_a = '{32'h000F0000, 32'h000F0001, 32'h000F0003, 32'h00100000, 32'h00100000};
    exp_d = '{32'h1, 32'h2, 32'h3, 32'h4};
    exp_w = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tick();
    tick();
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_awvalid", AWVALID, 1'b0);
    chk1("rst_rdready", RDREADY, 1'b0);
    chk32("rst_awaddr", AWADDR, 32'h0);
    chk32("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    tick();
    // single write, always-ready responder
    rsp_ready = 1'b1;
    push(1'b1, 32'h000F0000, 32'hDEADBEEF);
    chk1("wr_n1_awvalid", AWVALID, 1'b0);
    chk1("wr_n1_busy", busy, 1'b1);
    tick();
    chk1("wr_n2_awvalid", AWVALID, 1'b1);
    chk32("wr_n2_awaddr", AWADDR, 32'h000F0000);
    chk1("wr_n2_wdvalid", WDVALID, 1'b0);
    tick();
    chk1("wr_n3_wdvalid", WDVALID, 1'b1);
    chk1("wr_n3_awvalid", AWVALID, 1'b0);
    chk32("wr_n3_wdata", WDATA, 32'hDEADBEEF);
    tick();
    chk1("wr_n4_rsp_valid", rsp_valid, 1'b1);
    chk1("wr_n4_rsp_write", rsp_write, 1'b1);
    chk1("wr_n4_rsp_error", rsp_error, 1'b0);
    chk32("wr_n4_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    chk1("wr_done_rsp_valid", rsp_valid, 1'b0);
    chk1("wr_done_busy", busy, 1'b0);
    // read with slow responder
    rsp_ready = 1'b0;
    ARREADY = 1'b0;
    RDVALID = 1'b0;
    push(1'b0, 32'h00000040, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk1("rd_arvalid_hold", ARVALID, 1'b1);
      chk32("rd_araddr_hold", ARADDR, 32'h00000040);
      tick();
    end
    chk1("rd_arvalid_hs", ARVALID, 1'b1);
    chk32("rd_araddr_hs", ARADDR, 32'h00000040);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    chk1("rd_arvalid_drop", ARVALID, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1("rd_rdready_wait", RDREADY, 1'b1);
      chk1("rd_no_rsp_yet", rsp_valid, 1'b0);
      tick();
    end
    chk1("rd_rdready_hs", RDREADY, 1'b1);
    RDVALID = 1'b1;
    RDATA = 32'h12345678;
    tick();
    RDVALID = 1'b0;
    RDATA = 32'h0;
    chk1("rd_rsp_valid", rsp_valid, 1'b1);
    chk1("rd_rsp_write", rsp_write, 1'b0);
    chk1("rd_rsp_error", rsp_error, 1'b0);
    chk32("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk1("rd_done_busy", busy, 1'b0);
    // FIFO full with response held off
    ARREADY = 1'b1;
    RDVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk1("ff_cmd_ready", cmd_ready, 1'b1);
      push(1'b1, 32'h100 + i, i);
    end
    chk1("ff_full", cmd_ready, 1'b0);
    chk1("ff_rsp0_valid", rsp_valid, 1'b1);
    push(1'b1, 32'hBAD, 32'hBAD);
    chk1("ff_still_full", cmd_ready, 1'b0);
    rsp_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      for (int t = 0; t < 10 && !AWVALID; t++) tick();
      chk1("ff_aw_seen", AWVALID, 1'b1);
      chk32("ff_awaddr", AWADDR, 32'h100 + k);
      for (int t = 0; t < 10 && !WDVALID; t++) tick();
      chk1("ff_w_seen", WDVALID, 1'b1);
      chk32("ff_wdata", WDATA, k);
      for (int t = 0; t < 10 && !rsp_valid; t++) tick();
      chk1("ff_rsp_seen", rsp_valid, 1'b1);
    end
    tick();
    tick();
    chk1("ff_drained_busy", busy, 1'b0);
    chk1("ff_drained_awvalid", AWVALID, 1'b0);
    chk1("ff_drained_ready", cmd_ready, 1'b1);
    rsp_ready = 1'b0;
    // timeout in the W phase
    WDREADY = 1'b0;
    push(1'b1, 32'h200, 32'hAA);
    tick();
    chk1("to_awvalid", AWVALID, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk1("to_wdvalid_high", WDVALID, 1'b1);
      tick();
    end
    chk1("to_wdvalid_drop", WDVALID, 1'b0);
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_rsp_error", rsp_error, 1'b1);
    chk1("to_rsp_write", rsp_write, 1'b1);
    chk32("to_rsp_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    WDREADY = 1'b1;
    // reset while in R with two commands queued
    RDVALID = 1'b0;
    push(1'b0, 32'h300, 32'h0);
    push(1'b1, 32'h304, 32'h5);
    push(1'b1, 32'h308, 32'h6);
    chk1("mr_in_r", RDREADY, 1'b1);
    chk1("mr_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk1("mr_cmd_ready", cmd_ready, 1'b1);
    chk1("mr_busy_clr", busy, 1'b0);
    chk1("mr_rdready", RDREADY, 1'b0);
    chk1("mr_arvalid", ARVALID, 1'b0);
    chk1("mr_awvalid", AWVALID, 1'b0);
    chk1("mr_rsp_valid", rsp_valid, 1'b0);
    chk32("mr_araddr", ARADDR, 32'h0);
    rst = 1'b0;
    RDVALID = 1'b1;
    RDATA = 32'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("mr_no_rsp", rsp_valid, 1'b0);
      chk1("mr_idle", busy, 1'b0);
    end
    // matmul sequence observed by the monitor
    RDATA = 32'hCAFEF00D;
    rsp_ready = 1'b1;
    mon = 1'b1;
    push(1'b1, 32'h000F0000, 32'h1);
    push(1'b1, 32'h000F0001, 32'h2);
    push(1'b1, 32'h000F0003, 32'h3);
    push(1'b1, 32'h00100000, 32'h4);
    push(1'b0, 32'h00100000, 32'h0);
    for (int t = 0; t < 60 && r < 5; t++) tick();
    tick();
    tick();
    mon = 1'b0;
    chk32("mm_txn_count", n, 5);
    chk32("mm_wdata_count", m, 4);
    chk32("mm_rsp_count", r, 5);
    chk1("mm_busy", busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
